// File: rtl/gs_pkg.sv
// Shared types and constants for the greedy nearest-neighbour search controller.
package gs_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    REQ,
    STREAM,
    DRAIN,
    DECIDE,
    DONE
  } state_t;

  localparam logic [31:0] DIST_MAX = 32'hFFFF_FFFF;

  localparam int VID_BITS_DEFAULT = 16;
  typedef logic [VID_BITS_DEFAULT-1:0] vid_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with combinational head read; a simultaneous pop frees
// the slot the push needs, so push while full is accepted when it is paired with a pop.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             pop_eff;
  logic             push_eff;

  assign empty    = (count_reg == '0);
  assign pop_eff  = pop && !empty;
  assign push_eff = push && ((count_reg != CW'(DEPTH)) || pop_eff);
  assign dout     = mem_reg[rd_ptr_reg];
  assign count    = count_reg;

  always_ff @(posedge clk) begin
    if (push_eff) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_eff) begin
        wr_ptr_reg <= (wr_ptr_reg == AW'(DEPTH - 1)) ? '0 : wr_ptr_reg + AW'(1);
      end
      if (pop_eff) begin
        rd_ptr_reg <= (rd_ptr_reg == AW'(DEPTH - 1)) ? '0 : rd_ptr_reg + AW'(1);
      end
      case ({push_eff, pop_eff})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/greedy_search_ctrl.sv
// Walks the graph greedily from an entry vertex towards the query, one neighbour
// list per hop, until no neighbour is closer or the hop limit is reached.
module greedy_search_ctrl
  import gs_pkg::*;
#(
  parameter int DIM         = 4,
  parameter int VID_BITS    = 16,
  parameter int MAX_HOPS    = 64,
  parameter int OUTSTANDING = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic [VID_BITS-1:0]   entry_vid_in,
  input  logic [DIM*32-1:0]     entry_pos_in,
  input  logic [DIM*32-1:0]     query_pos_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic [VID_BITS-1:0]   best_vid_out,
  output logic [31:0]           best_dist_out,
  output logic [7:0]            hops_out,
  output logic                  fetch_req_out,
  output logic [VID_BITS-1:0]   fetch_vid_out,
  input  logic                  fetch_ready_in,
  input  logic                  neigh_valid_in,
  input  logic [VID_BITS-1:0]   neigh_vid_in,
  input  logic [DIM*32-1:0]     neigh_pos_in,
  input  logic                  neigh_nil_in,
  input  logic                  neigh_last_in,
  output logic                  neigh_ready_out,
  output logic                  dist_valid_out,
  output logic [DIM*32-1:0]     dist_vertex_out,
  output logic [DIM*32-1:0]     dist_query_out,
  input  logic                  dist_valid_in,
  input  logic [31:0]           dist_in
);

  localparam int CNT_W = $clog2(OUTSTANDING) + 1;
  localparam logic [8:0] HOP_LIMIT = 9'(MAX_HOPS);

  state_t                state_reg, state_next;
  logic [DIM*32-1:0]     query_reg;
  logic [DIM*32-1:0]     entry_pos_reg;
  logic [VID_BITS-1:0]   cur_reg;
  logic [VID_BITS-1:0]   best_vid_reg;
  logic [31:0]           best_dist_reg;
  logic [7:0]            hops_reg;
  logic                  improved_reg;
  logic                  seed_pending_reg;

  logic                  tag_push;
  logic [VID_BITS-1:0]   tag_din;
  logic [VID_BITS-1:0]   tag_dout;
  logic                  tag_empty;
  logic [CNT_W-1:0]      tag_count;
  logic                  result_take;
  logic [8:0]            hops_inc;
  logic                  hop_room;

  // Result tags queue in issue order; the distance unit answers in the same order.
  sync_fifo #(
    .WIDTH (VID_BITS),
    .DEPTH (OUTSTANDING)
  ) u_tag_fifo (
    .clk   (clk_in),
    .srst  (rst_in),
    .push  (tag_push),
    .din   (tag_din),
    .pop   (dist_valid_in),
    .dout  (tag_dout),
    .empty (tag_empty),
    .count (tag_count)
  );

  assign result_take   = dist_valid_in && !tag_empty;
  assign hops_inc      = {1'b0, hops_reg} + 9'd1;
  assign hop_room      = (hops_inc < HOP_LIMIT);

  assign busy_out      = (state_reg != IDLE);
  assign best_vid_out  = best_vid_reg;
  assign best_dist_out = best_dist_reg;
  assign hops_out      = hops_reg;
  assign dist_query_out = query_reg;

  always_comb begin
    state_next      = state_reg;
    done_out        = 1'b0;
    fetch_req_out   = 1'b0;
    fetch_vid_out   = '0;
    neigh_ready_out = 1'b0;
    dist_valid_out  = 1'b0;
    dist_vertex_out = '0;
    tag_push        = 1'b0;
    tag_din         = '0;
    case (state_reg)
      IDLE: begin
        if (start_in) state_next = SEED;
      end
      SEED: begin
        dist_valid_out  = 1'b1;
        dist_vertex_out = entry_pos_reg;
        tag_push        = 1'b1;
        tag_din         = cur_reg;
        state_next      = REQ;
      end
      REQ: begin
        fetch_req_out = 1'b1;
        fetch_vid_out = cur_reg;
        if (fetch_ready_in) state_next = STREAM;
      end
      STREAM: begin
        neigh_ready_out = (tag_count < CNT_W'(OUTSTANDING));
        if (neigh_valid_in && neigh_ready_out) begin
          if (!neigh_nil_in) begin
            dist_valid_out  = 1'b1;
            dist_vertex_out = neigh_pos_in;
            tag_push        = 1'b1;
            tag_din         = neigh_vid_in;
          end
          if (neigh_last_in) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (tag_count == '0) state_next = DECIDE;
      end
      DECIDE: begin
        state_next = (improved_reg && hop_room) ? REQ : DONE;
      end
      DONE: begin
        done_out   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg        <= IDLE;
      query_reg        <= '0;
      entry_pos_reg    <= '0;
      cur_reg          <= '0;
      best_vid_reg     <= '0;
      best_dist_reg    <= '0;
      hops_reg         <= '0;
      improved_reg     <= 1'b0;
      seed_pending_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start_in) begin
            query_reg     <= query_pos_in;
            entry_pos_reg <= entry_pos_in;
            cur_reg       <= entry_vid_in;
            best_vid_reg  <= entry_vid_in;
            best_dist_reg <= DIST_MAX;
            hops_reg      <= '0;
            improved_reg  <= 1'b0;
          end
        end
        SEED: seed_pending_reg <= 1'b1;
        REQ: begin
          if (fetch_ready_in) improved_reg <= 1'b0;
        end
        DECIDE: begin
          if (improved_reg) begin
            if (hops_inc <= HOP_LIMIT) hops_reg <= hops_inc[7:0];
            if (hop_room) cur_reg <= best_vid_reg;
          end
        end
        default: ;
      endcase
      // The first result after SEED is the entry's own distance: it sets the
      // baseline but must not count as a move-worthy improvement.
      if (result_take) begin
        seed_pending_reg <= 1'b0;
        if (dist_in < best_dist_reg) begin
          best_dist_reg <= dist_in;
          best_vid_reg  <= tag_dout;
          if (!seed_pending_reg) improved_reg <= 1'b1;
        end
      end
    end
  end

endmodule
